// File: rtl/controleur_lancer_pkg.sv
// Shared definitions for the dice-roll controller: FSM encoding, die-size table
// and the LFSR seed/feedback mask.
package controleur_lancer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_HOLD = 2'd2
    } etat_t;

    localparam logic [2:0]  TYPE_RESET = 3'd1;
    localparam logic [2:0]  TYPE_LAST  = 3'd6;

    // Taps 16,14,13,11 expressed for a right-shifting register (bits 0,2,3,5).
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'b0000_0000_0010_1101;

    function automatic logic [6:0] taille_de(input logic [2:0] idx);
        logic [6:0] n;
        case (idx)
            3'd0:    n = 7'd4;
            3'd1:    n = 7'd6;
            3'd2:    n = 7'd8;
            3'd3:    n = 7'd10;
            3'd4:    n = 7'd12;
            3'd5:    n = 7'd20;
            3'd6:    n = 7'd100;
            default: n = 7'd6;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] type_suivant(input logic [2:0] idx);
        return (idx >= TYPE_LAST) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/controleur_lancer_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running every cycle; used as the entropy source
// for dice samples.
module lfsr16
    import controleur_lancer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {^(q_q & LFSR_TAPS), q_q[15:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/controleur_lancer.sv
// Dice-roll controller: selects the die type, animates a roll of ROLL_STEPS
// samples spaced TICK_DIV cycles apart, then holds the final value.
module controleur_lancer
    import controleur_lancer_pkg::*;
#(
    parameter int TICK_DIV   = 16,
    parameter int ROLL_STEPS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_lancer,
    input  logic       btn_type,
    output logic [6:0] min_de,
    output logic [6:0] max_de,
    output logic [6:0] valeur,
    output logic       afficher_type,
    output logic       busy,
    output logic       done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(ROLL_STEPS - 1);

    etat_t         etat_q, etat_d;
    logic [2:0]    type_q, type_d;
    logic [6:0]    min_q;
    logic [6:0]    max_q, max_d;
    logic [6:0]    valeur_q, valeur_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] step_q, step_d;
    logic          done_q, done_d;
    logic          lancer_prev_q, type_prev_q;

    logic          front_lancer, front_type;
    logic [15:0]   lfsr;
    logic [6:0]    sample;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    assign front_lancer = btn_lancer & ~lancer_prev_q;
    assign front_type   = btn_type   & ~type_prev_q;

    // max_q is never zero, so the modulo is always defined and lands in [1, N].
    assign sample = 7'(lfsr % 16'(max_q)) + 7'd1;

    always_comb begin
        etat_d   = etat_q;
        type_d   = type_q;
        valeur_d = valeur_q;
        tick_d   = tick_q;
        step_d   = step_q;
        done_d   = 1'b0;

        case (etat_q)
            ST_IDLE, ST_HOLD: begin
                if (front_lancer) begin
                    etat_d = ST_ROLL;
                    tick_d = '0;
                    step_d = '0;
                end else if (front_type) begin
                    type_d = type_suivant(type_q);
                    etat_d = ST_IDLE;
                end
            end
            ST_ROLL: begin
                if (tick_q == TICK_LAST) begin
                    tick_d   = '0;
                    valeur_d = sample;
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        etat_d = ST_HOLD;
                        done_d = 1'b1;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                etat_d = ST_IDLE;
            end
        endcase

        max_d = taille_de(type_d);
    end

    // Button history resets high so a button held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            etat_q        <= ST_IDLE;
            type_q        <= TYPE_RESET;
            min_q         <= 7'd1;
            max_q         <= 7'd6;
            valeur_q      <= 7'd0;
            tick_q        <= '0;
            step_q        <= '0;
            done_q        <= 1'b0;
            lancer_prev_q <= 1'b1;
            type_prev_q   <= 1'b1;
        end else begin
            etat_q        <= etat_d;
            type_q        <= type_d;
            min_q         <= 7'd1;
            max_q         <= max_d;
            valeur_q      <= valeur_d;
            tick_q        <= tick_d;
            step_q        <= step_d;
            done_q        <= done_d;
            lancer_prev_q <= btn_lancer;
            type_prev_q   <= btn_type;
        end
    end

    assign min_de        = min_q;
    assign max_de        = max_q;
    assign valeur        = valeur_q;
    assign done          = done_q;
    assign busy          = (etat_q == ST_ROLL);
    assign afficher_type = (etat_q == ST_IDLE);

endmodule
